// File: rtl/sumdiff_mult_seq.sv
// sumdiff_mult_seq: computes (x+y)*(y-x) = y^2 - x^2 with a sequential
// shift-add multiplier and logs every result into a circular RAM.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start, x, y   request and unsigned operands (accepted only while idle)
//   busy          operation in progress
//   done          one-cycle pulse: product valid, RAM entry written
//   product       signed result, held until the next done
//   rd_addr       result RAM read address
//   rd_data       registered RAM read data (one-cycle latency)
//   count         number of stored results, saturates at DEPTH
//   wr_ptr        RAM address the next result goes to
module sumdiff_mult_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = 2 * WIDTH + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] product,
  input  logic [AW-1:0] rd_addr,
  output logic [PW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic [AW-1:0] wr_ptr
);

  localparam int unsigned OW = WIDTH + 1;        // sum / diff width
  localparam int unsigned IW = $clog2(WIDTH + 2); // iteration counter width
  localparam int unsigned CW = AW + 1;            // count width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [OW-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic            sign_q, sign_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic            busy_d, done_d;
  logic [PW-1:0]   product_d;
  logic [CW-1:0]   count_d;
  logic [AW-1:0]   wr_ptr_d;

  logic [OW-1:0]   sum_c, diff_c, mag_c;
  logic [PW-1:0]   result_c;
  logic            we_c;

  logic [PW-1:0]   ram [DEPTH];

  // Operand preprocessing: magnitude of y-x drives the multiplier, its sign
  // is reapplied at the end so the engine itself stays unsigned.
  assign sum_c    = OW'(x) + OW'(y);
  assign diff_c   = OW'(y) - OW'(x);
  assign mag_c    = diff_c[WIDTH] ? (OW'(0) - diff_c) : diff_c;
  assign result_c = sign_q ? (PW'(0) - acc_q) : acc_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    sign_d    = sign_q;
    iter_d    = iter_q;
    busy_d    = busy;
    done_d    = 1'b0;
    product_d = product;
    count_d   = count;
    wr_ptr_d  = wr_ptr;
    we_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = PW'(sum_c);
          mplier_d = mag_c;
          sign_d   = diff_c[WIDTH];
          acc_d    = '0;
          iter_d   = '0;
          busy_d   = 1'b1;
          state_d  = MUL;
        end
      end
      MUL: begin
        // One multiplier bit per cycle, LSB first
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + IW'(1);
        if (iter_q == IW'(WIDTH)) state_d = WRITE;
      end
      WRITE: begin
        product_d = result_c;
        we_c      = 1'b1;
        wr_ptr_d  = wr_ptr + AW'(1);
        count_d   = (count == CW'(DEPTH)) ? count : count + CW'(1);
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      iter_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      count    <= '0;
      wr_ptr   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      iter_q   <= iter_d;
      busy     <= busy_d;
      done     <= done_d;
      product  <= product_d;
      count    <= count_d;
      wr_ptr   <= wr_ptr_d;
    end
  end

  // Result RAM write; contents are not reset, a reset edge suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && we_c) ram[wr_ptr] <= result_c;
  end

  // Registered read port, read-before-write on a same-address collision
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= ram[rd_addr];
  end

endmodule
